// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-zero constant, hazard FSM states and the
// mult/div latency default that ALU64 and the hazard controller must agree on.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO           = 5'd0;
  localparam int         MULDIV_LAT_DEFAULT = 4;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage MIPS pipeline: load-use stalls, EX redirects,
// HI/LO busy window tracking and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       Rs_DEC,
  input  logic [4:0]       Rt_DEC,
  input  logic             UsesRs_DEC,
  input  logic             UsesRt_DEC,
  input  logic             MulDiv_DEC,
  input  logic             ReadsHiLo_DEC,
  input  logic             MemRead_EX,
  input  logic [4:0]       Dest_EX,
  input  logic             Redirect_EX,
  output logic             PCWrite,
  output logic             IFDWrite,
  output logic             FlushIF,
  output logic             BubbleDEC,
  output logic             HiLoBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int CW = $clog2(MULDIV_LAT + 1);

  generate
    if ((MULDIV_LAT < 1) || (MULDIV_LAT > 15)) begin : g_bad_lat
      $error("pipeline_hazard_ctrl: MULDIV_LAT must be in 1..15");
    end
  endgenerate

  hz_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           loaduse;
  logic           hilo_stall;
  logic           stall;
  logic           issue;

  always_comb begin
    loaduse    = MemRead_EX && (Dest_EX != REG_ZERO) &&
                 ((UsesRs_DEC && (Rs_DEC == Dest_EX)) ||
                  (UsesRt_DEC && (Rt_DEC == Dest_EX)));
    hilo_stall = (state_q == HZ_BUSY) && (MulDiv_DEC || ReadsHiLo_DEC);
    stall      = (loaduse || hilo_stall) && !Redirect_EX;
    issue      = MulDiv_DEC && !stall && !Redirect_EX;
  end

  // Priority mux; while reset is held the pipeline runs with normal-flow controls.
  always_comb begin
    PCWrite   = 1'b1;
    IFDWrite  = 1'b1;
    FlushIF   = 1'b0;
    BubbleDEC = 1'b0;
    if (Rst) begin
      if (Redirect_EX) begin
        FlushIF   = 1'b1;
        BubbleDEC = 1'b1;
      end else if (stall) begin
        PCWrite   = 1'b0;
        IFDWrite  = 1'b0;
        BubbleDEC = 1'b1;
      end
    end
  end

  // HI/LO window: a redirect does not stop an op that already left DEC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_IDLE: begin
        if (issue) begin
          cnt_d   = CW'(MULDIV_LAT);
          state_d = HZ_BUSY;
        end
      end
      HZ_BUSY: begin
        if (issue) begin
          cnt_d = CW'(MULDIV_LAT);
        end else if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = HZ_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = HZ_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign HiLoBusy = (state_q == HZ_BUSY);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (stall),
    .count (StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (Redirect_EX),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with a cycle-time behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int     LAT  = 4;
  localparam int     CW   = 8;
  localparam longint MAXC = (64'd1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [4:0]    Rs_DEC, Rt_DEC, Dest_EX;
  logic          UsesRs_DEC, UsesRt_DEC, MulDiv_DEC, ReadsHiLo_DEC;
  logic          MemRead_EX, Redirect_EX;
  logic          PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy;
  logic [CW-1:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  // Model: HI/LO is busy in every cycle up to and including busy_end.
  int     now      = 0;
  int     busy_end = -1;
  longint m_stalls = 0;
  longint m_flush  = 0;
  bit     m_stall;
  logic [4:0] exp_ctl;

  pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .Rs_DEC(Rs_DEC), .Rt_DEC(Rt_DEC),
    .UsesRs_DEC(UsesRs_DEC), .UsesRt_DEC(UsesRt_DEC),
    .MulDiv_DEC(MulDiv_DEC), .ReadsHiLo_DEC(ReadsHiLo_DEC),
    .MemRead_EX(MemRead_EX), .Dest_EX(Dest_EX), .Redirect_EX(Redirect_EX),
    .PCWrite(PCWrite), .IFDWrite(IFDWrite), .FlushIF(FlushIF),
    .BubbleDEC(BubbleDEC), .HiLoBusy(HiLoBusy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  task automatic drive_idle();
    Rs_DEC = 0; Rt_DEC = 0; Dest_EX = 0;
    UsesRs_DEC = 0; UsesRt_DEC = 0; MulDiv_DEC = 0; ReadsHiLo_DEC = 0;
    MemRead_EX = 0; Redirect_EX = 0;
  endtask

  task automatic model_eval();
    bit lu, busy, hs;
    busy = (now <= busy_end);
    lu   = MemRead_EX && (Dest_EX != 0) &&
           ((UsesRs_DEC && Rs_DEC == Dest_EX) || (UsesRt_DEC && Rt_DEC == Dest_EX));
    hs   = busy && (MulDiv_DEC || ReadsHiLo_DEC);
    m_stall = (lu || hs) && !Redirect_EX && Rst;
    if (!Rst)             exp_ctl = 5'b11000;
    else if (Redirect_EX) exp_ctl = {4'b1111, busy};
    else if (m_stall)     exp_ctl = {4'b0001, busy};
    else                  exp_ctl = {4'b1100, busy};
  endtask

  // Wait for the clock edge and apply the cycle's effects to the model.
  task automatic tick();
    model_eval();
    @(posedge Clk);
    if (Rst) begin
      if (m_stall)     m_stalls = (m_stalls < MAXC) ? m_stalls + 1 : MAXC;
      if (Redirect_EX) m_flush  = (m_flush  < MAXC) ? m_flush  + 1 : MAXC;
      if (MulDiv_DEC && !m_stall && !Redirect_EX) busy_end = now + LAT;
    end
    now++;
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    Rst = 1'b0;
    busy_end = -1; m_stalls = 0; m_flush = 0;
    @(posedge Clk); #1;
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    drive_idle();
    Redirect_EX = 1; MemRead_EX = 1; Dest_EX = 8; UsesRs_DEC = 1; Rs_DEC = 8;
    @(negedge Clk);
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp %b", {PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy}, 5'b11000);
    end
    checks++;
    if (StallCount !== '0 || FlushCount !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", StallCount, FlushCount);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    MemRead_EX = 1; Dest_EX = 8; UsesRs_DEC = 1; Rs_DEC = 8; Rt_DEC = 3;
    @(negedge Clk);
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC} !== 4'b0001) begin
      errors++;
      $display("FAIL load_use_stall got %b exp 0001", {PCWrite, IFDWrite, FlushIF, BubbleDEC});
    end
    tick();
    MemRead_EX = 0; Dest_EX = 0;
    @(negedge Clk);
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC} !== 4'b1100) begin
      errors++;
      $display("FAIL load_use_release got %b exp 1100", {PCWrite, IFDWrite, FlushIF, BubbleDEC});
    end
    checks++;
    if (StallCount !== CW'(1)) begin
      errors++;
      $display("FAIL load_use_count got %0d exp 1", StallCount);
    end
    tick();
  endtask

  task automatic test_dest_zero();
    do_reset();
    MemRead_EX = 1; Dest_EX = 0; UsesRs_DEC = 1; Rs_DEC = 0; UsesRt_DEC = 1; Rt_DEC = 0;
    @(negedge Clk);
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy} !== 5'b11000) begin
      errors++;
      $display("FAIL dest_zero got %b exp 11000", {PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy});
    end
    tick();
    checks++;
    if (StallCount !== '0) begin
      errors++;
      $display("FAIL dest_zero_count got %0d exp 0", StallCount);
    end
  endtask

  task automatic test_hilo_stall();
    do_reset();
    MulDiv_DEC = 1;
    tick();
    MulDiv_DEC = 0; ReadsHiLo_DEC = 1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge Clk);
      checks++;
      if ({PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy} !== 5'b00011) begin
        errors++;
        $display("FAIL hilo_stall cyc%0d got %b exp 00011", i, {PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy});
      end
      tick();
    end
    @(negedge Clk);
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy} !== 5'b11000) begin
      errors++;
      $display("FAIL hilo_release got %b exp 11000", {PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy});
    end
    checks++;
    if (StallCount !== CW'(LAT)) begin
      errors++;
      $display("FAIL hilo_count got %0d exp %0d", StallCount, LAT);
    end
    // A new mult/div may issue in the cycle the window closes.
    ReadsHiLo_DEC = 0; MulDiv_DEC = 1;
    tick();
    drive_idle();
    @(negedge Clk);
    checks++;
    if (HiLoBusy !== 1'b1) begin
      errors++;
      $display("FAIL hilo_reissue got %b exp 1", HiLoBusy);
    end
    for (int i = 0; i < LAT; i++) tick();
  endtask

  task automatic test_redirect_priority();
    do_reset();
    MemRead_EX = 1; Dest_EX = 9; UsesRt_DEC = 1; Rt_DEC = 9; Redirect_EX = 1;
    @(negedge Clk);
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC} !== 4'b1111) begin
      errors++;
      $display("FAIL redirect_ctl got %b exp 1111", {PCWrite, IFDWrite, FlushIF, BubbleDEC});
    end
    tick();
    drive_idle();
    @(negedge Clk);
    checks++;
    if (StallCount !== '0 || FlushCount !== CW'(1)) begin
      errors++;
      $display("FAIL redirect_count got %0d/%0d exp 0/1", StallCount, FlushCount);
    end
  endtask

  task automatic test_redirect_mult();
    do_reset();
    MulDiv_DEC = 1; Redirect_EX = 1;
    tick();
    drive_idle();
    ReadsHiLo_DEC = 1;
    @(negedge Clk);
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy} !== 5'b11000) begin
      errors++;
      $display("FAIL redirect_mult got %b exp 11000", {PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy});
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    MemRead_EX = 1; Dest_EX = 4; UsesRs_DEC = 1; Rs_DEC = 4;
    tick();
    drive_idle();
    MulDiv_DEC = 1;
    tick();
    drive_idle();
    tick();
    tick();
    @(negedge Clk);
    checks++;
    if (HiLoBusy !== 1'b1 || StallCount !== CW'(1)) begin
      errors++;
      $display("FAIL pre_reset_busy got busy=%b stalls=%0d exp busy=1 stalls=1", HiLoBusy, StallCount);
    end
    @(posedge Clk); #2;
    Redirect_EX = 1;
    Rst = 1'b0;
    #1;
    checks++;
    if ({PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy} !== 5'b11000 ||
        StallCount !== '0 || FlushCount !== '0) begin
      errors++;
      $display("FAIL async_reset got ctl=%b cnt=%0d/%0d exp 11000 0/0",
               {PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy}, StallCount, FlushCount);
    end
    now++;
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    MemRead_EX = 1; Dest_EX = 5; UsesRs_DEC = 1; Rs_DEC = 5;
    for (int i = 0; i < int'(MAXC); i++) tick();
    checks++;
    if (StallCount !== '1) begin
      errors++;
      $display("FAIL stall_sat_reach got %0d exp %0d", StallCount, MAXC);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (StallCount !== '1) begin
      errors++;
      $display("FAIL stall_sat_hold got %0d exp %0d", StallCount, MAXC);
    end
    drive_idle();
    Redirect_EX = 1;
    for (int i = 0; i < int'(MAXC) + 4; i++) tick();
    checks++;
    if (FlushCount !== '1 || StallCount !== '1) begin
      errors++;
      $display("FAIL flush_sat got %0d/%0d exp %0d/%0d", FlushCount, StallCount, MAXC, MAXC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      Dest_EX       = 5'($urandom_range(0, 3));
      Rs_DEC        = 5'($urandom_range(0, 3));
      Rt_DEC        = 5'($urandom_range(0, 3));
      UsesRs_DEC    = $urandom_range(0, 1);
      UsesRt_DEC    = $urandom_range(0, 1);
      MemRead_EX    = ($urandom_range(0, 99) < 40);
      MulDiv_DEC    = ($urandom_range(0, 99) < 20);
      ReadsHiLo_DEC = ($urandom_range(0, 99) < 30);
      Redirect_EX   = ($urandom_range(0, 99) < 12);
      @(negedge Clk);
      model_eval();
      checks++;
      if ({PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy} !== exp_ctl) begin
        errors++;
        $display("FAIL random_ctl cyc%0d got %b exp %b", i, {PCWrite, IFDWrite, FlushIF, BubbleDEC, HiLoBusy}, exp_ctl);
      end
      checks++;
      if (StallCount !== CW'(m_stalls) || FlushCount !== CW'(m_flush)) begin
        errors++;
        $display("FAIL random_cnt cyc%0d got %0d/%0d exp %0d/%0d", i, StallCount, FlushCount, m_stalls, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load_use();
    test_dest_zero();
    test_hilo_stall();
    test_redirect_priority();
    test_redirect_mult();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
